// File: rtl/sram22_param_model.sv
// rtl/sram22_param_model.sv - parametrised single-port SRAM22 stand-in with zeroise sweep
// Options: SRAM22_OUT_REG_EN (second output register, latency 2), USE_POWER_PINS (vdd/vss pins).
module sram22_param_model #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int WMASK_WIDTH = 4
) (
`ifdef USE_POWER_PINS
  inout  wire                    vdd,
  inout  wire                    vss,
`endif
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   ce,
  input  logic                   we,
  input  logic [WMASK_WIDTH-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]  din,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   dout_valid,
  output logic                   ready
);

  localparam int SEG   = DATA_WIDTH / WMASK_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  generate
    if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_mask
      $error("sram22_param_model: DATA_WIDTH must be a multiple of WMASK_WIDTH");
    end
  endgenerate

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   cur_word;
  logic [DATA_WIDTH-1:0]   merged;
  logic                    access;
  logic [DATA_WIDTH-1:0]   q1;
  logic                    v1;

  assign ready    = (state == IDLE);
  assign access   = ce && ready;
  assign cur_word = mem[addr];

  // Merged word doubles as read data: with we=0 no segment is replaced.
  always_comb begin
    merged = cur_word;
    for (int k = 0; k < WMASK_WIDTH; k++) begin
      if (we && wmask[k]) merged[k*SEG +: SEG] = din[k*SEG +: SEG];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (clr_addr == '1) state_nxt = IDLE;
      IDLE:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
    end
  end

  // While reset is held the sweep points at address 0, which the sweep zeroes again anyway.
  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[clr_addr] <= '0;
    else if (access && we) mem[addr] <= merged;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      q1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= access;
      if (access) q1 <= merged;
    end
  end

`ifdef SRAM22_OUT_REG_EN
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= v1;
      if (v1) dout <= q1;
    end
  end
`else
  assign dout       = q1;
  assign dout_valid = v1;
`endif

endmodule

// File: tb/tb_sram22_param_model.sv
// tb/tb_sram22_param_model.sv - directed bench for sram22_param_model (default 512x32, 4 mask segments)
module tb_sram22_param_model;

`ifdef SRAM22_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rstb;
  logic        ce;
  logic        we;
  logic [3:0]  wmask;
  logic [8:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        dout_valid;
  logic        ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] s_d [3];
  logic        s_v [3];

  sram22_param_model #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WMASK_WIDTH(4)) dut (
    .clk(clk), .rstb(rstb), .ce(ce), .we(we), .wmask(wmask), .addr(addr),
    .din(din), .dout(dout), .dout_valid(dout_valid), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic acc(input logic w, input logic [3:0] m, input logic [8:0] a,
                     input logic [31:0] d, input logic [31:0] exp, input string tag);
    ce = 1'b1; we = w; wmask = m; addr = a; din = d;
    step();
    ce = 1'b0; we = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      chk({tag, " early valid"}, {31'b0, dout_valid}, 32'd0);
      step();
    end
    chk(tag, dout, exp);
    chk({tag, " valid"}, {31'b0, dout_valid}, 32'd1);
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 511; i++) step();
    chk({tag, " ready before edge 512"}, {31'b0, ready}, 32'd0);
    step();
    chk({tag, " ready at edge 512"}, {31'b0, ready}, 32'd1);
  endtask

  initial begin
    rstb = 1'b0; ce = 1'b0; we = 1'b0; wmask = 4'h0; addr = 9'h0; din = 32'h0;
    step();
    step();
    chk("reset dout", dout, 32'h0);
    chk("reset dout_valid", {31'b0, dout_valid}, 32'd0);
    chk("reset ready", {31'b0, ready}, 32'd0);

    // Release; a write attempt held throughout the sweep must be ignored.
    rstb = 1'b1;
    ce = 1'b1; we = 1'b1; wmask = 4'hF; addr = 9'h030; din = 32'hFFFF_FFFF;
    sweep("sweep1");
    ce = 1'b0; we = 1'b0;
    chk("pre-ready valid", {31'b0, dout_valid}, 32'd0);
    step();
    chk("pre-ready valid late", {31'b0, dout_valid}, 32'd0);
    chk("pre-ready dout", dout, 32'h0);

    acc(1'b0, 4'h0, 9'h000, 32'h0, 32'h0000_0000, "read 000");
    acc(1'b0, 4'h0, 9'h0FF, 32'h0, 32'h0000_0000, "read 0FF");
    acc(1'b0, 4'h0, 9'h1FF, 32'h0, 32'h0000_0000, "read 1FF");

    acc(1'b1, 4'b1111, 9'h005, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "write 005 full");
    acc(1'b1, 4'b0101, 9'h005, 32'h1122_3344, 32'hDE22_BE44, "write 005 mask0101");
    acc(1'b0, 4'h0,    9'h005, 32'h0,         32'hDE22_BE44, "read 005");
    acc(1'b1, 4'b0000, 9'h005, 32'hFFFF_FFFF, 32'hDE22_BE44, "write 005 mask0000");
    acc(1'b0, 4'h0,    9'h005, 32'h0,         32'hDE22_BE44, "read 005 after noop");

    // Write then read the same address with ce held high.
    ce = 1'b1; we = 1'b1; wmask = 4'hF; addr = 9'h010; din = 32'hA5A5_A5A5;
    step(); s_d[0] = dout; s_v[0] = dout_valid;
    we = 1'b0; din = 32'h0;
    step(); s_d[1] = dout; s_v[1] = dout_valid;
    ce = 1'b0;
    step(); s_d[2] = dout; s_v[2] = dout_valid;
    chk("b2b write dout", s_d[LAT-1], 32'hA5A5_A5A5);
    chk("b2b write valid", {31'b0, s_v[LAT-1]}, 32'd1);
    chk("b2b read dout", s_d[LAT], 32'hA5A5_A5A5);
    chk("b2b read valid", {31'b0, s_v[LAT]}, 32'd1);

    ce = 1'b0; we = 1'b1; wmask = 4'hF; addr = 9'h020; din = 32'hFFFF_FFFF;
    step();
    chk("ce0 dout hold", dout, 32'hA5A5_A5A5);
    chk("ce0 valid", {31'b0, dout_valid}, 32'd0);
    we = 1'b0;
    acc(1'b0, 4'h0, 9'h020, 32'h0, 32'h0000_0000, "read 020 after ce0");
    acc(1'b0, 4'h0, 9'h030, 32'h0, 32'h0000_0000, "read 030 after sweep write");

    acc(1'b1, 4'hF, 9'h1FF, 32'h1234_5678, 32'h1234_5678, "write 1FF");
    #3 rstb = 1'b0;
    #1;
    chk("mid reset dout", dout, 32'h0);
    chk("mid reset ready", {31'b0, ready}, 32'd0);
    chk("mid reset valid", {31'b0, dout_valid}, 32'd0);
    step();
    rstb = 1'b1;
    sweep("sweep2");
    acc(1'b0, 4'h0, 9'h1FF, 32'h0, 32'h0000_0000, "read 1FF after resweep");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
